mmu_wr_seq: RTL and testbench
=============================

// Module: mmu_wr_seq
// PURPOSE
//  Write-side sequencer of the MMU, the counterpart of the read-address step counter.
//  Accepts an element stream on a valid/ready handshake and writes it to SRAM at stepped
//  addresses until the target is reached.
//  Two modes:
//   - single (mm_ss=0): one element per memory word.
//   - packed (mm_ss=1): 4 elements per word, merged in a word buffer with a byte-lane mask.
// PARAMETERS
//  DIM_ADDR  12  address / counter width
//  DIM_STEP  3   step input width
//  DIM_DATA  8   element width; memory word = 4*DIM_DATA
// PORTS
//  clk        in   1            clock, all state on rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  start      in   1            launch a run (sampled in IDLE only)
//  abort      in   1            cancel current run
//  target     in   DIM_ADDR     exclusive end: element idx (single) / word addr (packed)
//  step       in   DIM_STEP     counter increment per accepted element
//  mm_ss      in   1            1 = packed mode, 0 = single mode
//  in_valid   in   1            element available
//  in_data    in   DIM_DATA     element
//  in_ready   out  1            element accepted when in_valid & in_ready
//  mem_we     out  1            one-cycle write strobe
//  mem_addr   out  DIM_ADDR     write address
//  mem_wdata  out  4*DIM_DATA   write data, lane k = bits [k*DIM_DATA +: DIM_DATA]
//  mem_wmask  out  4            lane enables
//  busy       out  1            run in progress
//  done       out  1            one-cycle pulse at run end
//  err        out  1            one-cycle pulse with done: step==0 or counter overflow
// BEHAVIOUR
//  Reset values: all outputs 0; FSM IDLE; cnt, word buffer and mask cleared.
//  FSM IDLE->RUN: start && step!=0.
//   - target, step and mm_ss are latched.
//   - cnt is set to 0.
//   - busy is high from the next cycle.
//  IDLE->DONE: start && step==0.
//   - No writes are issued.
//   - done and err pulse in the next cycle.
//  RUN: in_ready=1 in every RUN cycle; no memory backpressure exists.
//  Accepted element at cnt:
//   - cnt_nxt = cnt + step, DIM_ADDR+1 bits wide.
//   - last = mm_ss ? (cnt_nxt>>2)==target : cnt_nxt==target.
//   - ovf  = cnt_nxt[DIM_ADDR] && !last.
//  Single mode, write registered 1 cycle after acceptance:
//   - mem_addr = cnt.
//   - mem_wdata = in_data zero-extended.
//   - mem_wmask = 4'b1111.
//  Packed mode: element merges into lane cnt[1:0] of the buffer and sets that mask bit.
//  Packed flush (registered, next cycle): when (cnt_nxt>>2)!=(cnt>>2), or last, or ovf.
//   - mem_addr = cnt>>2; wdata/mask taken from the buffer including the current element.
//   - Buffer and mask clear after flush.
//   - Unwritten lanes keep mask 0; steps >4 leave whole words unwritten.
//  RUN->DONE: on last or ovf acceptance.
//   - The final write and the state change occur in the same cycle.
//   - done (err if ovf) pulses in the cycle after the final mem_we.
//   - DONE->IDLE unconditionally.
//  abort in RUN:
//   - Partial packed word discarded; no write, no done.
//   - IDLE next cycle; abort has priority over a same-cycle acceptance.
//  start while busy: ignored. rst_n low mid-run: immediate return to reset values.
//  Inputs other than start/abort/in_* are don't-care outside IDLE.
// STRUCTURE
//  Shared package:
//   - FSM state encoding (IDLE/RUN/DONE).
//   - LANES=4, LANE_BITS=2, mode constants.
//  Sub-module mmu_step_cnt: counter with clr/en/step.
//   - Outputs cnt and the DIM_ADDR+1 wide cnt_nxt.
//   - Outputs last/ovf using the mm_ss compare.
//  The top module holds the FSM, word buffer and write register.
// TESTING
//  1 Single, target=4, step=1, data 11,22,33,44 ->
//    4 writes, addr 0..3, wdata 0x00000011..0x00000044, mask F; done 1 cycle after the 4th write.
//  2 Packed, target=2, step=1, data A0..A7 ->
//    addr0 A3A2A1A0 mask F; addr1 A7A6A5A4 mask F; done, err=0.
//  3 Packed, target=2, step=3, data 01,02,03 ->
//    addr0 wdata xx02xx01 (lanes 3,0), mask 1001; addr1 lane2=03, mask 0100; done after the 3rd element.
//  4 Single, target=5, step=4 ->
//    1024 writes at addr 0,4,...,0xFFC; then done+err together.
//  5 Packed, abort after 2 elements -> no mem_we, no done, busy low next cycle.
//    Start with step=0 -> done+err, no writes.
//  6 rst_n low mid-run -> all outputs 0 immediately; start during RUN ignored;
//    in_valid gaps stall the counter without spurious writes.

Source files
------------

// File: rtl/mmu_wr_seq_pkg.sv
// Shared types and constants for the MMU write-side sequencer.
// No logic; FSM encoding, lane geometry and mode values.
// Imported by mmu_step_cnt and mmu_wr_seq.
package mmu_wr_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int   LANES       = 4;
    localparam int   LANE_BITS   = 2;
    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_PACKED = 1'b1;

    function automatic logic [LANES-1:0] lane_bit(input logic [LANE_BITS-1:0] lane);
        logic [LANES-1:0] m;
        m       = '0;
        m[lane] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/mmu_step_cnt.sv
// Step counter: cnt advances by step on en, clears on clr; reports last/overflow.
// Latency: cnt updates on the enabling edge; cnt_nxt/last/ovf are combinational.
// Backpressure: none, en is the caller's accept strobe.
module mmu_step_cnt
    import mmu_wr_seq_pkg::*;
#(
    parameter int DIM_ADDR = 12,
    parameter int DIM_STEP = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic [DIM_STEP-1:0] step,
    input  logic                mm_ss,
    input  logic [DIM_ADDR-1:0] target,
    output logic [DIM_ADDR-1:0] cnt,
    output logic [DIM_ADDR:0]   cnt_nxt,
    output logic                last,
    output logic                ovf
);

    logic [DIM_ADDR-LANE_BITS:0] word_nxt;

    // Carry bit kept so a wrap past the address space is visible as overflow.
    assign cnt_nxt  = {1'b0, cnt} + {{(DIM_ADDR+1-DIM_STEP){1'b0}}, step};
    assign word_nxt = cnt_nxt[DIM_ADDR:LANE_BITS];

    always_comb begin
        if (mm_ss == MODE_PACKED)
            last = ({1'b0, word_nxt} == {{(LANE_BITS){1'b0}}, target});
        else
            last = (cnt_nxt == {1'b0, target});
        ovf = cnt_nxt[DIM_ADDR] && !last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt_nxt[DIM_ADDR-1:0];
    end

endmodule

// File: rtl/mmu_wr_seq.sv
// MMU write sequencer: streams elements to SRAM at stepped addresses, single or 4-lane packed.
// Latency: memory write registered one cycle after acceptance; done one cycle after final write.
// Backpressure: in_ready high in every RUN cycle; memory side never stalls.
module mmu_wr_seq
    import mmu_wr_seq_pkg::*;
#(
    parameter int DIM_ADDR = 12,
    parameter int DIM_STEP = 3,
    parameter int DIM_DATA = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DIM_ADDR-1:0]       target,
    input  logic [DIM_STEP-1:0]       step,
    input  logic                      mm_ss,
    input  logic                      in_valid,
    input  logic [DIM_DATA-1:0]       in_data,
    output logic                      in_ready,
    output logic                      mem_we,
    output logic [DIM_ADDR-1:0]       mem_addr,
    output logic [LANES*DIM_DATA-1:0] mem_wdata,
    output logic [LANES-1:0]          mem_wmask,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    state_t                    state;
    logic [DIM_ADDR-1:0]       tgt_q;
    logic [DIM_STEP-1:0]       step_q;
    logic                      mode_q;
    logic                      err_pend;
    logic [LANES*DIM_DATA-1:0] wbuf;
    logic [LANES-1:0]          wmask;
    logic [LANES*DIM_DATA-1:0] wbuf_mrg;
    logic [LANES-1:0]          wmask_mrg;

    logic                      cnt_clr;
    logic                      acc;
    logic                      word_chg;
    logic                      flush;
    logic [DIM_ADDR-1:0]       cnt;
    logic [DIM_ADDR:0]         cnt_nxt;
    logic                      last;
    logic                      ovf;

    // in_ready is only ever high in RUN, so it doubles as the RUN qualifier.
    assign cnt_clr  = (state == ST_IDLE) && start;
    assign acc      = in_ready && in_valid && !abort;
    assign word_chg = (cnt_nxt >> LANE_BITS) != ({1'b0, cnt} >> LANE_BITS);
    assign flush    = word_chg || last || ovf;

    mmu_step_cnt #(
        .DIM_ADDR (DIM_ADDR),
        .DIM_STEP (DIM_STEP)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (acc),
        .step    (step_q),
        .mm_ss   (mode_q),
        .target  (tgt_q),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .last    (last),
        .ovf     (ovf)
    );

    always_comb begin
        wbuf_mrg  = wbuf;
        wbuf_mrg[cnt[LANE_BITS-1:0]*DIM_DATA +: DIM_DATA] = in_data;
        wmask_mrg = wmask | lane_bit(cnt[LANE_BITS-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tgt_q     <= '0;
            step_q    <= '0;
            mode_q    <= MODE_SINGLE;
            err_pend  <= 1'b0;
            wbuf      <= '0;
            wmask     <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tgt_q  <= target;
                        step_q <= step;
                        mode_q <= mm_ss;
                        wbuf   <= '0;
                        wmask  <= '0;
                        if (step != '0) begin
                            state    <= ST_RUN;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end else begin
                            state    <= ST_DONE;
                            err_pend <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b0;
                        wbuf     <= '0;
                        wmask    <= '0;
                    end else if (acc) begin
                        if (mode_q == MODE_SINGLE) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= cnt;
                            mem_wdata <= {{((LANES-1)*DIM_DATA){1'b0}}, in_data};
                            mem_wmask <= '1;
                        end else if (flush) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= cnt >> LANE_BITS;
                            mem_wdata <= wbuf_mrg;
                            mem_wmask <= wmask_mrg;
                            wbuf      <= '0;
                            wmask     <= '0;
                        end else begin
                            wbuf  <= wbuf_mrg;
                            wmask <= wmask_mrg;
                        end
                        if (last || ovf) begin
                            state    <= ST_DONE;
                            in_ready <= 1'b0;
                            err_pend <= ovf;
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    err      <= err_pend;
                    err_pend <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmu_wr_seq.sv
// Directed bench for mmu_wr_seq: single/packed runs, overflow, abort, step=0, reset, stalls.
// Writes and done pulses are logged on the falling edge and compared to hand-computed values.
module tb_mmu_wr_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [11:0] target;
    logic [2:0]  step;
    logic        mm_ss;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        busy;
    logic        done;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    mmu_wr_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .target    (target),
        .step      (step),
        .mm_ss     (mm_ss),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write/done log, sampled mid-cycle.
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_dat_q[$];
    logic [31:0] wr_msk_q[$];
    int          mon_wr_cyc    = 0;
    int          mon_done_n    = 0;
    int          mon_done_cyc  = 0;
    logic        mon_done_err  = 1'b0;
    int          mon_stray_err = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back({20'h0, mem_addr});
            wr_dat_q.push_back(mem_wdata);
            wr_msk_q.push_back({28'h0, mem_wmask});
            mon_wr_cyc = cyc;
        end
        if (done) begin
            mon_done_n   = mon_done_n + 1;
            mon_done_cyc = cyc;
            mon_done_err = err;
        end else if (err) begin
            mon_stray_err = mon_stray_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic m, input logic [11:0] t, input logic [2:0] s);
        tick();
        start  = 1'b1;
        mm_ss  = m;
        target = t;
        step   = s;
        tick();
        start  = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int dbase, input int max);
        int k = 0;
        while (mon_done_n == dbase && k < max) begin
            tick();
            k++;
        end
        repeat (3) tick();
    endtask

    int wb, db;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        target   = '0;
        step     = '0;
        mm_ss    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #12;
        chk("rst_ctl",   {27'h0, mem_we, busy, done, err, in_ready}, 32'h0);
        chk("rst_addr",  {20'h0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_wmask", {28'h0, mem_wmask}, 32'h0);
        tick();
        rst_n = 1'b1;

        // 1: single mode, four elements
        wb = wr_addr_q.size(); db = mon_done_n;
        start_run(1'b0, 12'd4, 3'd1);
        chk("t1_busy", {31'h0, busy}, 32'h1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        wait_done(db, 20);
        chk("t1_nwr", wr_addr_q.size() - wb, 4);
        for (int i = 0; i < 4; i++) begin
            if (wb + i < wr_addr_q.size()) begin
                chk($sformatf("t1_addr%0d", i), wr_addr_q[wb+i], i);
                chk($sformatf("t1_dat%0d", i),  wr_dat_q[wb+i], 32'h11 * (i + 1));
                chk($sformatf("t1_msk%0d", i),  wr_msk_q[wb+i], 32'hF);
            end
        end
        chk("t1_done", mon_done_n - db, 1);
        chk("t1_err",  {31'h0, mon_done_err}, 32'h0);
        chk("t1_lat",  mon_done_cyc - mon_wr_cyc, 1);

        // 2: packed, two full words
        wb = wr_addr_q.size(); db = mon_done_n;
        start_run(1'b1, 12'd2, 3'd1);
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
        wait_done(db, 20);
        chk("t2_nwr", wr_addr_q.size() - wb, 2);
        if (wr_addr_q.size() >= wb + 2) begin
            chk("t2_addr0", wr_addr_q[wb],   32'h0);
            chk("t2_dat0",  wr_dat_q[wb],    32'hA3A2A1A0);
            chk("t2_msk0",  wr_msk_q[wb],    32'hF);
            chk("t2_addr1", wr_addr_q[wb+1], 32'h1);
            chk("t2_dat1",  wr_dat_q[wb+1],  32'hA7A6A5A4);
            chk("t2_msk1",  wr_msk_q[wb+1],  32'hF);
        end
        chk("t2_done", mon_done_n - db, 1);
        chk("t2_err",  {31'h0, mon_done_err}, 32'h0);

        // 3: packed, step 3 leaves lanes unwritten
        wb = wr_addr_q.size(); db = mon_done_n;
        start_run(1'b1, 12'd2, 3'd3);
        send(8'h01); send(8'h02); send(8'h03);
        wait_done(db, 20);
        chk("t3_nwr", wr_addr_q.size() - wb, 2);
        if (wr_addr_q.size() >= wb + 2) begin
            chk("t3_addr0", wr_addr_q[wb],   32'h0);
            chk("t3_dat0",  wr_dat_q[wb],    32'h02000001);
            chk("t3_msk0",  wr_msk_q[wb],    32'h9);
            chk("t3_addr1", wr_addr_q[wb+1], 32'h1);
            chk("t3_dat1",  wr_dat_q[wb+1],  32'h00030000);
            chk("t3_msk1",  wr_msk_q[wb+1],  32'h4);
        end
        chk("t3_done", mon_done_n - db, 1);
        chk("t3_err",  {31'h0, mon_done_err}, 32'h0);
        chk("t3_lat",  mon_done_cyc - mon_wr_cyc, 1);

        // 4: single, target never hit -> counter overflow
        wb = wr_addr_q.size(); db = mon_done_n;
        start_run(1'b0, 12'd5, 3'd4);
        for (int i = 0; i < 1024; i++) send(8'(i));
        wait_done(db, 20);
        chk("t4_nwr", wr_addr_q.size() - wb, 1024);
        begin
            int bad = 0;
            for (int i = 0; i < 1024; i++) begin
                if (wb + i >= wr_addr_q.size()) bad++;
                else if (wr_addr_q[wb+i] != 32'(i * 4) || wr_dat_q[wb+i] != 32'(i % 256)) bad++;
            end
            chk("t4_seq_bad", bad, 0);
        end
        if (wr_addr_q.size() > 0) chk("t4_last_addr", wr_addr_q[wr_addr_q.size()-1], 32'hFFC);
        chk("t4_done", mon_done_n - db, 1);
        chk("t4_err",  {31'h0, mon_done_err}, 32'h1);
        chk("t4_lat",  mon_done_cyc - mon_wr_cyc, 1);

        // 5a: abort wins over a same-cycle final element
        wb = wr_addr_q.size(); db = mon_done_n;
        start_run(1'b1, 12'd1, 3'd1);
        send(8'hB0); send(8'hB1); send(8'hB2);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hB3;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("t5_busy",  {31'h0, busy}, 32'h0);
        chk("t5_ready", {31'h0, in_ready}, 32'h0);
        repeat (4) tick();
        chk("t5_nwr",  wr_addr_q.size() - wb, 0);
        chk("t5_done", mon_done_n - db, 0);

        // 5b: step 0
        wb = wr_addr_q.size(); db = mon_done_n;
        start_run(1'b0, 12'd4, 3'd0);
        chk("t5s_busy", {31'h0, busy}, 32'h0);
        wait_done(db, 10);
        chk("t5s_nwr",  wr_addr_q.size() - wb, 0);
        chk("t5s_done", mon_done_n - db, 1);
        chk("t5s_err",  {31'h0, mon_done_err}, 32'h1);

        // 6a: asynchronous reset mid-run
        start_run(1'b0, 12'd10, 3'd1);
        send(8'h99); send(8'h9A);
        chk("t6_pre_we", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl",  {27'h0, mem_we, busy, done, err, in_ready}, 32'h0);
        chk("t6_rst_addr", {20'h0, mem_addr}, 32'h0);
        chk("t6_rst_dat",  mem_wdata, 32'h0);
        tick();
        rst_n = 1'b1;

        // 6b: start while busy ignored; input gaps stall the counter
        wb = wr_addr_q.size(); db = mon_done_n;
        start_run(1'b0, 12'd3, 3'd1);
        send(8'h55);
        start  = 1'b1;
        mm_ss  = 1'b1;
        step   = 3'd2;
        target = 12'd0;
        tick();
        start = 1'b0;
        repeat (2) tick();
        send(8'h66);
        tick();
        send(8'h77);
        wait_done(db, 20);
        chk("t6_nwr", wr_addr_q.size() - wb, 3);
        for (int i = 0; i < 3; i++) begin
            if (wb + i < wr_addr_q.size()) begin
                chk($sformatf("t6_addr%0d", i), wr_addr_q[wb+i], i);
                chk($sformatf("t6_dat%0d", i),  wr_dat_q[wb+i], 32'h55 + 32'h11 * i);
            end
        end
        chk("t6_done", mon_done_n - db, 1);
        chk("t6_err",  {31'h0, mon_done_err}, 32'h0);
        chk("stray_err", mon_stray_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
